// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared DVS event types, sensor geometry and timing constants.
package dvs_ravens_pkg;
   localparam int CLK_PERIOD_NS      = 10;
   localparam int DVS_TS_TICK_CYCLES = 1000 / CLK_PERIOD_NS;
   localparam int DVS_X_ADDR_BITS    = 9;
   localparam int DVS_Y_ADDR_BITS    = 9;
   localparam int TIMESTAMP_BITS     = 48;
   localparam int DROP_COUNT_BITS    = 16;
   localparam int DVS_X_RES          = 346;
   localparam int DVS_Y_RES          = 260;
   typedef struct packed {
      logic [DVS_X_ADDR_BITS-1:0] x;
      logic [DVS_Y_ADDR_BITS-1:0] y;
      logic                       pol;
      logic [TIMESTAMP_BITS-1:0]  ts;
   } dvs_event_t;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PRESENT} tx_state_t;
   function automatic logic in_sensor(input logic [DVS_X_ADDR_BITS-1:0] x, input logic [DVS_Y_ADDR_BITS-1:0] y);
      return (x < DVS_X_ADDR_BITS'(DVS_X_RES)) && (y < DVS_Y_ADDR_BITS'(DVS_Y_RES));
   endfunction
endpackage

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: synchronous event FIFO with flush and registered full/empty flags.
module dvs_event_fifo
   import dvs_ravens_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  dvs_event_t wdata,
   output dvs_event_t rdata,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   dvs_event_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic          do_push, do_pop;
   assign do_push = push & !full;
   assign do_pop  = pop & !empty;
   assign wr_nxt  = wr_ptr + PW'(do_push);
   assign rd_nxt  = rd_ptr + PW'(do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];
   // full is exact for the next cycle; empty trails the pointers by one cycle,
   // which forms the load-path pipeline stage (the consumer never pops twice in a row)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         full   <= (wr_nxt - rd_nxt) == PW'(DEPTH);
         empty  <= wr_ptr == rd_ptr;
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/dvs_event_replay_tx.sv
// dvs_event_replay_tx: replays host-loaded DVS events onto the event stream at their
// scheduled microsecond times; owns the free-running timestamp base.
module dvs_event_replay_tx
   import dvs_ravens_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TICK_CYCLES = DVS_TS_TICK_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       ts_clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DVS_X_ADDR_BITS-1:0] in_x,
   input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
   input  logic                       in_pol,
   input  logic [TIMESTAMP_BITS-1:0]  in_ts,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DVS_X_ADDR_BITS-1:0] out_x,
   output logic [DVS_Y_ADDR_BITS-1:0] out_y,
   output logic                       out_pol,
   output logic [TIMESTAMP_BITS-1:0]  out_ts,
   output logic [TIMESTAMP_BITS-1:0]  now_ts,
   output logic [DROP_COUNT_BITS-1:0] drop_count,
   output logic                       late_flag
);
   localparam int PS_W = $clog2(TICK_CYCLES + 1);
   logic [PS_W-1:0] prescaler;
   logic            tick, accept, push, pop, due, first_wait;
   logic            fifo_full, fifo_empty;
   dvs_event_t      fifo_head, hold, out_ev;
   tx_state_t       state, state_nxt;
   assign tick     = enable && prescaler == PS_W'(TICK_CYCLES - 1);
   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready && !ts_clear;
   assign push     = accept && in_sensor(in_x, in_y);
   assign due      = enable && hold.ts <= now_ts;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         now_ts    <= '0;
      end else if (ts_clear) begin
         prescaler <= '0;
         now_ts    <= '0;
      end else if (enable) begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         now_ts    <= now_ts + TIMESTAMP_BITS'(tick);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_count <= '0;
      else if (ts_clear) drop_count <= '0;
      else if (accept && !push && drop_count != '1) drop_count <= drop_count + 1'b1;
   end
   dvs_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (ts_clear),
      .push  (push),
      .pop   (pop),
      .wdata ({in_x, in_y, in_pol, in_ts}),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else if (ts_clear) state <= ST_IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            pop       = !fifo_empty;
            state_nxt = fifo_empty ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: state_nxt = due ? ST_PRESENT : ST_WAIT;
         ST_PRESENT: if (out_ready) begin
            pop       = !fifo_empty;
            state_nxt = fifo_empty ? ST_IDLE : ST_WAIT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
   always_comb begin
      out_valid = state == ST_PRESENT;
      {out_x, out_y, out_pol, out_ts} = out_ev;
   end
   // lateness is judged once, on the first cycle an event sits in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= '0;
         out_ev     <= '0;
         first_wait <= 1'b0;
         late_flag  <= 1'b0;
      end else if (ts_clear) begin
         hold       <= '0;
         out_ev     <= '0;
         first_wait <= 1'b0;
         late_flag  <= 1'b0;
      end else begin
         first_wait <= pop;
         if (pop) hold <= fifo_head;
         if (state == ST_WAIT && due) out_ev <= hold;
         if (state == ST_WAIT && first_wait && hold.ts < now_ts) late_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dvs_event_replay_tx.sv
// tb_dvs_event_replay_tx: directed scoreboard bench for the DVS event replay transmitter.
module tb_dvs_event_replay_tx;
   logic        clk = 0, rst_n = 0, enable = 0, ts_clear = 0, in_valid = 0, in_pol = 0, out_ready = 0;
   logic        in_ready, out_valid, out_pol, late_flag, acc, early;
   logic [8:0]  in_x = 0, in_y = 0, out_x, out_y;
   logic [47:0] in_ts = 0, out_ts, now_ts;
   logic [15:0] drop_count;
   logic [66:0] sb [$];
   int          checks = 0, failures = 0, hs_count = 0, n_acc, hs0;

   always #5 clk = ~clk;

   dvs_event_replay_tx dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ts_clear(ts_clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_pol(in_pol), .in_ts(in_ts),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_pol(out_pol),
      .out_ts(out_ts), .now_ts(now_ts), .drop_count(drop_count), .late_flag(late_flag)
   );

   task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input logic [8:0] x, input logic [8:0] y, input logic pol, input logic [47:0] ts, output logic a);
      in_x = x; in_y = y; in_pol = pol; in_ts = ts; in_valid = 1;
      a = in_ready;
      step();
      in_valid = 0;
      if (a && x < 346 && y < 260) sb.push_back({x, y, pol, ts});
   endtask

   // scoreboard: every handshake must match the oldest outstanding expected event
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         hs_count++;
         chk("out_event", {out_x, out_y, out_pol, out_ts}, sb.size() != 0 ? sb.pop_front() : 'x);
      end
   end

   initial begin
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_now_ts", now_ts, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_drop", drop_count, 0);
      chk("rst_late", late_flag, 0);
      chk("rst_out_fields", {out_x, out_y, out_pol, out_ts}, 0);
      @(negedge clk);
      rst_n = 1;
      step();
      // 1: timestamp base
      enable = 1;
      repeat (100) step();
      chk("t1_now_ts", now_ts, 1);
      chk("t1_out_valid", out_valid, 0);
      chk("t1_in_ready", in_ready, 1);
      enable = 0;
      repeat (500) step();
      chk("t1_frozen", now_ts, 1);
      // 2: future event presented at its time, held stable
      ts_clear = 1;
      step();
      ts_clear = 0;
      chk("t2_clear_ts", now_ts, 0);
      push_ev(10, 20, 1, 5, acc);
      chk("t2_acc", acc, 1);
      enable = 1;
      early = 0;
      for (int n = 0; n < 1000 && now_ts != 5; n++) begin
         if (out_valid) early = 1;
         step();
      end
      chk("t2_reach_ts", now_ts, 5);
      chk("t2_not_early", early, 0);
      if (!out_valid) step();
      chk("t2_out_valid", out_valid, 1);
      chk("t2_fields", {out_x, out_y, out_pol, out_ts}, {9'd10, 9'd20, 1'b1, 48'd5});
      chk("t2_late", late_flag, 0);
      repeat (20) step();
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_fields", {out_x, out_y, out_pol, out_ts}, {9'd10, 9'd20, 1'b1, 48'd5});
      out_ready = 1;
      step();
      out_ready = 0;
      chk("t2_drop_valid", out_valid, 0);
      // 3: out-of-range events are consumed and counted
      push_ev(346, 0, 0, 1, acc);
      chk("t3_acc_x", acc, 1);
      push_ev(0, 260, 0, 1, acc);
      chk("t3_acc_y", acc, 1);
      chk("t3_drop", drop_count, 2);
      repeat (10) step();
      chk("t3_no_out", out_valid, 0);
      // 4: late event
      for (int n = 0; n < 10000 && now_ts != 50; n++) step();
      chk("t4_reach_ts", now_ts, 50);
      push_ev(100, 200, 0, 10, acc);
      chk("t4_lat0", out_valid, 0);
      step();
      chk("t4_lat1", out_valid, 0);
      step();
      chk("t4_lat2", out_valid, 0);
      step();
      chk("t4_lat3", out_valid, 1);
      chk("t4_out_ts", out_ts, 10);
      chk("t4_late", late_flag, 1);
      out_ready = 1;
      step();
      out_ready = 0;
      // 5: capacity and throughput
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         push_ev(9'(i), 9'(i + 1), i[0], 0, acc);
         if (acc) n_acc++;
      end
      chk("t5_accepted", n_acc, 9);
      chk("t5_in_ready_low", in_ready, 0);
      hs0 = hs_count;
      out_ready = 1;
      repeat (17) step();
      chk("t5_handshakes", hs_count - hs0, 9);
      chk("t5_sb_empty", sb.size(), 0);
      chk("t5_in_ready_high", in_ready, 1);
      chk("t5_idle", out_valid, 0);
      out_ready = 0;
      // 6: ts_clear with FIFO loaded and an event presented
      for (int i = 0; i < 5; i++) push_ev(9'(200 + i), 9'(i), 1, 0, acc);
      repeat (4) step();
      chk("t6_presenting", out_valid, 1);
      in_x = 300; in_y = 1; in_ts = 0; in_valid = 1; ts_clear = 1;
      step();
      ts_clear = 0;
      in_valid = 0;
      sb.delete();
      chk("t6_out_valid", out_valid, 0);
      chk("t6_now_ts", now_ts, 0);
      chk("t6_drop", drop_count, 0);
      chk("t6_late", late_flag, 0);
      chk("t6_in_ready", in_ready, 1);
      out_ready = 1;
      early = 0;
      repeat (20) begin
         step();
         if (out_valid) early = 1;
      end
      chk("t6_no_out", early, 0);
      out_ready = 0;
      // asynchronous reset mid-operation
      push_ev(5, 6, 1, 0, acc);
      repeat (4) step();
      chk("rst2_before", {out_valid, out_x}, {1'b1, 9'd5});
      @(negedge clk);
      #1 rst_n = 0;
      #1;
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_out_x", out_x, 0);
      chk("rst2_in_ready", in_ready, 1);
      sb.delete();
      #10 rst_n = 1;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
